// File: rtl/spi_adc128s.sv
// SPI mode-0 slave front end for the behavioural ADC128S model; all SPI pins oversampled in clk.
// Optional MISO_TRISTATE_EN: MISO floats (1'bz) instead of driving 0 while deselected.
module spi_adc128s #(
    parameter int unsigned FRAME_BITS  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SS_n,
    input  logic                  SCLK,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [FRAME_BITS-1:0] A2D_data,
    output logic [FRAME_BITS-1:0] cmd,
    output logic                  rdy
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic [SYNC_STAGES-1:0] ss_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   ss_prev_q, sclk_prev_q;
    logic                   ss_s, sclk_s, mosi_s;
    logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;

    logic [FRAME_BITS-1:0]  rx_q, rx_d;
    logic [FRAME_BITS-1:0]  tx_q, tx_d;
    logic [FRAME_BITS-1:0]  cmd_q, cmd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rdy_q, rdy_d;

    // Synchronizers reset to the idle bus state so reset release creates no edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            ss_prev_q   <= ss_s;
            sclk_prev_q <= sclk_s;
        end
    end

    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_fall   = ss_prev_q & ~ss_s;
    assign ss_rise   = ~ss_prev_q & ss_s;
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    always_comb begin
        rx_d  = rx_q;
        tx_d  = tx_q;
        cmd_d = cmd_q;
        cnt_d = cnt_q;
        rdy_d = rdy_q;
        if (ss_fall) begin
            tx_d  = A2D_data;
            cnt_d = '0;
            rdy_d = 1'b0;
        end else if (!ss_prev_q) begin
            // Covers the ss_rise cycle too, so a coincident last SCLK rise still counts.
            if (sclk_rise) begin
                rx_d = {rx_q[FRAME_BITS-2:0], mosi_s};
                if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // A fall before the first rise would drop bit 15.
            if (sclk_fall && cnt_q != '0) begin
                tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
            end
            if (ss_rise && cnt_d == CNT_FULL) begin
                cmd_d = rx_d;
                rdy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_q  <= '0;
            tx_q  <= '0;
            cmd_q <= '0;
            cnt_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            rx_q  <= rx_d;
            tx_q  <= tx_d;
            cmd_q <= cmd_d;
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
        end
    end

    assign cmd = cmd_q;
    assign rdy = rdy_q;

`ifdef MISO_TRISTATE_EN
    assign MISO = ss_s ? 1'bz : tx_q[FRAME_BITS-1];
`else
    assign MISO = ss_s ? 1'b0 : tx_q[FRAME_BITS-1];
`endif

endmodule

// File: tb/tb_spi_adc128s.sv
// Directed bench for spi_adc128s: a mode-0 master drives frames and a scoreboard checks MISO, cmd, rdy.
module tb_spi_adc128s;

    logic        clk;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [15:0] A2D_data;
    logic [15:0] cmd;
    logic        rdy;

    spi_adc128s dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .A2D_data (A2D_data),
        .cmd      (cmd),
        .rdy      (rdy)
    );

`ifdef MISO_TRISTATE_EN
    localparam logic MISO_IDLE = 1'bz;
`else
    localparam logic MISO_IDLE = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] miso;
        logic [15:0] cmd;
        logic        valid;
        logic        full;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors;
    int          miscompares;
    int          rdy_rises;
    logic        rdy_prev;
    logic [15:0] model_cmd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_prev <= 1'b0;
        end else begin
            rdy_prev <= rdy;
            if (rdy && !rdy_prev) rdy_rises <= rdy_rises + 1;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic half_sclk();
        repeat (5) @(negedge clk);
    endtask

    // Master side: SS_n low, nbits mode-0 cycles, optional SS_n release. MISO sampled before each rise.
    task automatic shift_bits(input logic [15:0] word, input int nbits, output logic [15:0] rd);
        rd = '0;
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 16) ? word[15-i] : 1'b1;
            half_sclk();
            if (i < 16) rd[15-i] = MISO;
            SCLK = 1'b1;
            half_sclk();
            SCLK = 1'b0;
        end
        half_sclk();
    endtask

    task automatic run_frame(input string tag, input logic [15:0] a2d, input logic [15:0] word,
                             input int nbits);
        exp_t        e;
        logic [15:0] rd;
        A2D_data = a2d;
        if (nbits == 16) model_cmd = word;
        e.miso  = a2d;
        e.cmd   = model_cmd;
        e.valid = (nbits == 16);
        e.full  = (nbits >= 16);
        sb_q.push_back(e);
        shift_bits(word, nbits, rd);
        SS_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_rdy_early"}, {15'b0, rdy}, 16'h0000);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'h0001, 16'h0000);
        end else begin
            e = sb_q.pop_front();
            if (e.full) chk({tag, "_miso"}, rd, e.miso);
            chk({tag, "_rdy"}, {15'b0, rdy}, {15'b0, e.valid});
            chk({tag, "_cmd"}, cmd, e.cmd);
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int          r0;
        logic [15:0] rd;
        vectors     = 0;
        miscompares = 0;
        rdy_rises   = 0;
        model_cmd   = '0;
        rst      = 1'b1;
        SS_n     = 1'b1;
        SCLK     = 1'b0;
        MOSI     = 1'b0;
        A2D_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_cmd", cmd, 16'h0000);
        chk("reset_rdy", {15'b0, rdy}, 16'h0000);
        chk("reset_miso", {15'b0, MISO}, {15'b0, MISO_IDLE});
        rst = 1'b0;
        repeat (4) @(negedge clk);

        run_frame("full", 16'h0505, 16'h0800, 16);

        // Deselect-only frame: rdy must clear, cmd must hold.
        SS_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("clr_rdy", {15'b0, rdy}, 16'h0000);
        chk("clr_cmd", cmd, 16'h0800);
        repeat (6) @(negedge clk);
        SS_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("clr_empty_rdy", {15'b0, rdy}, 16'h0000);
        chk("clr_empty_cmd", cmd, 16'h0800);
        repeat (4) @(negedge clk);

        r0 = rdy_rises;
        run_frame("b2b1", 16'h04F5, 16'h1800, 16);
        run_frame("b2b2", 16'h04F0, 16'h0000, 16);
        chk("b2b_rises", 16'(rdy_rises - r0), 16'h0002);

        run_frame("short", 16'h1111, 16'hFFFF, 12);
        run_frame("long", 16'h2222, 16'hA5A5, 17);
        run_frame("pre_rst", 16'h7E81, 16'h1234, 16);

        // Reset in the middle of a frame.
        A2D_data = 16'hFFFF;
        shift_bits(16'hFFFF, 8, rd);
        rst = 1'b1;
        #1;
        chk("midrst_cmd", cmd, 16'h0000);
        chk("midrst_rdy", {15'b0, rdy}, 16'h0000);
        chk("midrst_miso", {15'b0, MISO}, {15'b0, MISO_IDLE});
        model_cmd = '0;
        SS_n = 1'b1;
        SCLK = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        run_frame("post_rst", 16'hBEEF, 16'hC3A5, 16);

        // Idle noise while deselected.
        r0 = rdy_rises;
        for (int i = 0; i < 10; i++) begin
            MOSI = i[0];
            SCLK = 1'b1;
            repeat (5) @(negedge clk);
            SCLK = 1'b0;
            repeat (5) @(negedge clk);
        end
        chk("noise_miso", {15'b0, MISO}, {15'b0, MISO_IDLE});
        chk("noise_cmd", cmd, 16'hC3A5);
        chk("noise_rdy", {15'b0, rdy}, 16'h0001);
        chk("noise_rises", 16'(rdy_rises - r0), 16'h0000);
        run_frame("after_noise", 16'h0F0F, 16'h5A3C, 16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_adc128s.md
Name: spi_adc128s

Overview:
- SPI slave front end of the behavioural ADC128S 12-bit A2D model.
- Each frame shifts a 16-bit command in on MOSI while shifting the 16-bit A2D_data word out on MISO. SPI mode 0, MSB first.
- After a complete frame it latches the received command and raises rdy. The parent model edge-detects rdy to update its channel pointer and conversion value.
- All SPI pins are asynchronous to clk and are oversampled in the clk domain.

Parameters:
- FRAME_BITS, 16, bits per SPI frame; width of cmd and A2D_data.
- SYNC_STAGES, 2, flip-flop stages in each pin synchronizer for SS_n, SCLK and MOSI (minimum 2).

Ports:
- clk  input  1  system clock; the only clock; must be at least 8x the SCLK frequency.
- rst  input  1  asynchronous, active-high reset.
- SS_n  input  1  active-low slave select from master.
- SCLK  input  1  serial clock from master; idles low.
- MOSI  input  1  serial data from master.
- MISO  output  1  serial data to master.
- A2D_data  input  FRAME_BITS  word to transmit; sampled at frame start.
- cmd  output  FRAME_BITS  last complete command received.
- rdy  output  1  high from end of a valid frame until the next frame starts.

Behaviour:
- Synchronization: SS_n, SCLK and MOSI each pass through SYNC_STAGES flops. One further register per signal supplies the edge detect.
  - SCLK rise (sclk_rise), SCLK fall (sclk_fall), SS_n fall (ss_fall) and SS_n rise (ss_rise) are single-clk pulses in the clk domain.
- Frame start (ss_fall):
  - tx_shift <= A2D_data.
  - bit_cnt <= 0.
  - rdy <= 0.
  - cmd is unchanged.
- During frame (synchronized SS_n low):
  - sclk_rise: rx_shift <= {rx_shift[FRAME_BITS-2:0], MOSI_synced}; bit_cnt increments and saturates at FRAME_BITS+1.
  - sclk_fall: tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0}. A sclk_fall before the first sclk_rise of the frame is ignored, so bit 15 is never skipped.
  - MISO = tx_shift[FRAME_BITS-1], so bit 15 is presented before the first rising edge.
- Frame end (ss_rise):
  - If bit_cnt == FRAME_BITS exactly: cmd <= rx_shift and rdy <= 1 on the same clk edge.
  - Any other count (short or long frame): cmd and rdy are unchanged, and no rdy pulse occurs.
- Latency: the rdy rise occurs SYNC_STAGES+1 clk edges after the SS_n pin rises (3 clk with defaults).
- rdy is a level, not a pulse. It stays high until the next ss_fall or reset.
- SCLK and MOSI edges are ignored while SS_n is high.
- Simultaneous ss_rise and sclk_rise in the same clk: the bit is counted first, then the frame-end rule is applied to the updated count.
- Reset, including mid-frame: cmd=0, rdy=0, rx_shift=0, tx_shift=0, bit_cnt=0, all synchronizer flops reset to idle (SS_n=1, SCLK=0, MOSI=0). No edge pulses are generated on reset release.
- MISO while deselected: see Optional Feature.
- Timing requirements:
  - SCLK high and low phases are each at least 4 clk periods.
  - SS_n high time between frames is at least 4 clk periods.

Optional Feature:
- Macro MISO_TRISTATE_EN.
- Defined: MISO drives 1'bz whenever synchronized SS_n is high, so multiple slaves can share the line.
- Not defined: MISO drives 1'b0 whenever synchronized SS_n is high.
- While SS_n is low, behaviour is identical with or without the macro.

Test Plan:
- Reset: assert rst mid-frame -> cmd=16'h0000, rdy=0, MISO at its idle value (0 or z per macro); the next full frame works normally.
- Full frame: A2D_data=16'h0505, master sends 16'h0800 -> MISO bits read 16'h0505 MSB first; 3 clk after the SS_n pin rises, rdy=1 and cmd=16'h0800.
- rdy clear: after the previous frame, drive SS_n low -> rdy falls within 3 clk; cmd holds 16'h0800 until the next valid frame ends.
- Back-to-back frames: frame 1 with cmd 16'h1800 while A2D_data=16'h04F5, frame 2 with cmd 16'h0000 while A2D_data=16'h04F0 -> MISO returns 04F5 then 04F0; two distinct rdy rising edges; final cmd=16'h0000.
- Short frame: 12 SCLK cycles, then SS_n high -> rdy stays 0, cmd unchanged. Long frame of 17 cycles -> same result.
- Idle noise: toggle SCLK and MOSI with SS_n high -> no change to cmd, rdy or internal count; MISO stays at its idle value.
